// File: rtl/regr_pkg.sv
// Shared constants and types for the regression sample path (streamer, XTX, XTY, MAT_INV).
package regr_pkg;

   localparam int N        = 256;
   localparam int DW       = 12;
   localparam int AW       = 8;
   localparam int WAIT_MAX = 16;
   localparam int WCW      = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_START  = 2'd1,
      S_STREAM = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } sample_t;

endpackage

// File: rtl/regr_sample_streamer_sample_buf.sv
// One-write one-read sample buffer with synchronous read; the read register returns
// zero on any cycle without a read so the streamer's outputs idle at zero.
module sample_buf
   import regr_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  sample_t       wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output sample_t       rd_data
);

   sample_t mem [N];

   // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
      else            rd_data <= '0;
   end

endmodule

// File: rtl/regr_sample_streamer.sv
// Transmit side of the regression sample interface: buffers a batch of N (x,y) samples,
// streams them to the XTX/XTY accumulators after a start pulse, then waits for both results.
module regr_sample_streamer
   import regr_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_x,
   input  logic [DW-1:0] wr_y,
   input  logic          abort,
   output logic          start,
   output logic [DW-1:0] xi,
   output logic [DW-1:0] yi,
   input  logic          xtx_valid,
   input  logic          xty_valid,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [AW-1:0]  PTR_LAST    = AW'(N - 1);
   localparam logic [AW:0]    STREAM_LAST = (AW + 1)'(N - 1);
   localparam logic [WCW-1:0] WAIT_LAST   = WCW'(WAIT_MAX - 1);

   state_t         state_q, state_d;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    stream_cnt;
   logic [WCW-1:0] wait_cnt;
   logic           seen_xtx, seen_xty;
   logic           wr_fire, last_write, stream_last, both_seen, wait_expired;
   logic           rd_en, start_d, done_d, err_d;
   sample_t        rd_data;

   assign wr_fire      = wr_valid && wr_ready && !abort;
   assign last_write   = wr_fire && (wr_ptr == PTR_LAST);
   assign stream_last  = (stream_cnt == STREAM_LAST);
   assign both_seen    = (seen_xtx || xtx_valid) && (seen_xty || xty_valid);
   assign wait_expired = (wait_cnt == WAIT_LAST);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_LOAD;
         wr_ready <= 1'b1;
         busy     <= 1'b0;
         start    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ready <= (state_d == S_LOAD);
         busy     <= (state_d != S_LOAD);
         start    <= start_d;
         done     <= done_d;
         err      <= err_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_LOAD;
      end else begin
         unique case (state_q)
            S_LOAD:   if (last_write) state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: if (stream_last) state_d = S_WAIT;
            S_WAIT:   if (both_seen || wait_expired) state_d = S_LOAD;
            default:  state_d = S_LOAD;
         endcase
      end
   end

   // Done wins over err when both valids land on the final wait cycle
   always_comb begin
      start_d = (state_d == S_START);
      done_d  = !abort && (state_q == S_WAIT) && both_seen;
      err_d   = !abort && (state_q == S_WAIT) && !both_seen && wait_expired;
      rd_en   = !abort && ((state_q == S_START) || ((state_q == S_STREAM) && !stream_last));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         stream_cnt <= '0;
         wait_cnt   <= '0;
         seen_xtx   <= 1'b0;
         seen_xty   <= 1'b0;
      end else if (abort) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         stream_cnt <= '0;
         wait_cnt   <= '0;
         seen_xtx   <= 1'b0;
         seen_xty   <= 1'b0;
      end else begin
         if (wr_fire) wr_ptr <= last_write ? '0 : wr_ptr + AW'(1);
         if (rd_en)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
         stream_cnt <= (state_q == S_STREAM) ? stream_cnt + (AW + 1)'(1) : '0;
         if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            wait_cnt <= wait_cnt + WCW'(1);
            seen_xtx <= seen_xtx || xtx_valid;
            seen_xty <= seen_xty || xty_valid;
         end else begin
            wait_cnt <= '0;
            seen_xtx <= 1'b0;
            seen_xty <= 1'b0;
         end
      end
   end

   sample_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_fire),
      .wr_addr (wr_ptr),
      .wr_data ({wr_x, wr_y}),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign xi = rd_data.x;
   assign yi = rd_data.y;

endmodule

// File: tb/tb_regr_sample_streamer.sv
// Directed bench for regr_sample_streamer with a behavioural XTX/XTY sink stub.
module tb_regr_sample_streamer;
   import regr_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_x = '0;
   logic [DW-1:0] wr_y = '0;
   logic          abort = 1'b0;
   logic          start;
   logic [DW-1:0] xi, yi;
   logic          xtx_valid, xty_valid;
   logic          busy, done, err;

   int n_vec = 0;
   int n_bad = 0;

   // Sink stub configuration (valid delay in cycles after the last streamed sample, 0 = never) and results
   int sink_xd = 3;
   int sink_yd = 3;
   int ans0 = 0, ans1 = 0, ans_y = 0;

   always #5 clk = ~clk;

   regr_sample_streamer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .abort     (abort),
      .start     (start),
      .xi        (xi),
      .yi        (yi),
      .xtx_valid (xtx_valid),
      .xty_valid (xty_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_x(input int pat, input int k);
      return (pat == 0) ? k : 255 - k;
   endfunction

   function automatic int exp_y(input int pat, input int k);
      return (pat == 0) ? 2 * k : (k * 7) % 4096;
   endfunction

   // Stub accumulator: samples xi/yi in the N cycles after start, then raises the valids
   initial begin
      int a0, a1, ay, m;
      xtx_valid = 1'b0;
      xty_valid = 1'b0;
      forever begin
         tick();
         if (start === 1'b1) begin
            a0 = 0; a1 = 0; ay = 0;
            for (int i = 0; i < N; i++) begin
               tick();
               a0 = a0 + 1;
               a1 = a1 + int'(xi);
               ay = ay + int'(yi);
            end
            ans0 = a0; ans1 = a1; ans_y = ay;
            m = (sink_xd > sink_yd) ? sink_xd : sink_yd;
            for (int d = 1; d <= m + 1; d++) begin
               tick();
               xtx_valid = (d == sink_xd);
               xty_valid = (d == sink_yd);
            end
         end
      end
   end

   // Loads one batch, checks the start handshake, then watches stream and completion for a fixed window
   task automatic run_batch(input int pat, input bit stall, input bit junk, input int xd, input int yd,
                            input int abort_at, input int exp_done_t, input int exp_err_t);
      int early, bad, done_t, err_t, n_done, n_err, ex, ey;
      sink_xd = xd;
      sink_yd = yd;
      early = 0;
      for (int k = 0; k < N; k++) begin
         if (stall) begin
            wr_valid = 1'b0;
            tick();
         end
         wr_valid = 1'b1;
         wr_x = DW'(exp_x(pat, k));
         wr_y = DW'(exp_y(pat, k));
         if (start !== 1'b0 || wr_ready !== 1'b1) early++;
         tick();
      end
      wr_valid = 1'b0;
      check("early_start", early, 0);
      check("start_pulse", start, 1);
      check("ready_low", wr_ready, 0);
      check("busy_high", busy, 1);

      bad = 0; done_t = -1; err_t = -1; n_done = 0; n_err = 0;
      for (int t = 1; t <= N + 30; t++) begin
         tick();
         abort = 1'b0;
         wr_valid = junk && (t < N);
         if (junk) begin
            wr_x = '1;
            wr_y = '1;
         end
         ex = (t <= N && t <= abort_at) ? exp_x(pat, t - 1) : 0;
         ey = (t <= N && t <= abort_at) ? exp_y(pat, t - 1) : 0;
         if (xi !== DW'(ex) || yi !== DW'(ey)) bad++;
         if (done === 1'b1) begin
            if (done_t < 0) done_t = t;
            n_done++;
         end
         if (err === 1'b1) begin
            if (err_t < 0) err_t = t;
            n_err++;
         end
         if (t == abort_at + 1) begin
            check("abort_ready", wr_ready, 1);
            check("abort_busy", busy, 0);
         end
         if (t == abort_at) abort = 1'b1;
      end
      wr_valid = 1'b0;
      check("stream_data", bad, 0);
      check("done_count", n_done, (exp_done_t > 0) ? 1 : 0);
      check("done_cycle", done_t, exp_done_t);
      check("err_count", n_err, (exp_err_t > 0) ? 1 : 0);
      check("err_cycle", err_t, exp_err_t);
      check("idle_ready", wr_ready, 1);
      check("idle_busy", busy, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wr_ready"}, wr_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_xi"}, xi, 0);
      check({tag, "_yi"}, yi, 0);
   endtask

   initial begin
      #12;
      check_reset_values("rst");
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_values("post_rst");

      // Plain batch x=k, y=2k with standard sinks
      run_batch(0, 1'b0, 1'b0, 3, 3, 1000, N + 4, -1);
      check("xtx_ans0", ans0, 256);
      check("xtx_ans1", ans1, 32640);
      check("xty_sum_y", ans_y, 65280);

      // Stalled load, junk writes offered while streaming
      run_batch(0, 1'b1, 1'b1, 3, 3, 1000, N + 4, -1);

      // Staggered valids
      run_batch(1, 1'b0, 1'b0, 3, 6, 1000, N + 7, -1);

      // Sinks never respond
      run_batch(0, 1'b0, 1'b0, 0, 0, 1000, -1, N + 17);

      // Abort while sample 100 is on the bus, then a clean batch
      run_batch(1, 1'b0, 1'b0, 3, 3, 101, -1, -1);
      run_batch(0, 1'b0, 1'b0, 3, 3, 1000, N + 4, -1);

      // Reset with 57 samples loaded
      for (int k = 0; k < 57; k++) begin
         wr_valid = 1'b1;
         wr_x = DW'(k + 100);
         wr_y = DW'(k);
         tick();
      end
      wr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_wr_ready", wr_ready, 1);
      run_batch(1, 1'b0, 1'b0, 3, 3, 1000, N + 4, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
